// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter: round-robin arbiter wrapping requester commands in the LCD driver initlcd/strobe/ack protocol; optional lock input under LCD_ARB_LOCK_EN
module lcd_cmd_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 65535,
  parameter int TO_W    = 16
) (
  input  logic              CCLK,
  input  logic              debpb0_n,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] cmd,
  input  logic [8*NREQ-1:0] dat,
`ifdef LCD_ARB_LOCK_EN
  input  logic [NREQ-1:0]   lock,
`endif
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic              busy,
  output logic              resetlcd,
  output logic              clearlcd,
  output logic              homelcd,
  output logic              datalcd,
  output logic              addrlcd,
  output logic              initlcd,
  output logic [7:0]        lcddatin,
  input  logic              lcdreset,
  input  logic              lcdclear,
  input  logic              lcdhome,
  input  logic              lcddata,
  input  logic              lcdaddr
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, INIT_HI, INIT_LO, ISSUE} state_t;
  state_t state;
  logic [IW-1:0] ptr, cur, rr_win, win;
  logic [2:0] op, wcmd;
  logic [7:0] d;
  logic [TO_W-1:0] cnt;
  logic ack;
`ifdef LCD_ARB_LOCK_EN
  logic lk;
`endif
  always_comb begin
    rr_win = ptr;
    for (int k = NREQ; k >= 1; k--)
      if (req[IW'((int'(ptr) + k) % NREQ)]) rr_win = IW'((int'(ptr) + k) % NREQ);
`ifdef LCD_ARB_LOCK_EN
    win = (lk && req[cur]) ? cur : rr_win;
`else
    win = rr_win;
`endif
  end
  assign wcmd = cmd[3*win +: 3];
  assign ack = (op == 3'd0 && lcdreset) || (op == 3'd1 && lcdclear) || (op == 3'd2 && lcdhome) ||
               (op == 3'd3 && lcddata) || (op == 3'd4 && lcdaddr);
  always_ff @(posedge CCLK or negedge debpb0_n)
    if (!debpb0_n) begin
      state    <= IDLE;
      ptr      <= IW'(NREQ - 1);
      cur      <= '0;
      op       <= '0;
      d        <= '0;
      cnt      <= '0;
      gnt      <= '0;
      done     <= '0;
      err      <= '0;
      busy     <= 1'b0;
      initlcd  <= 1'b0;
      resetlcd <= 1'b0;
      clearlcd <= 1'b0;
      homelcd  <= 1'b0;
      datalcd  <= 1'b0;
      addrlcd  <= 1'b0;
      lcddatin <= '0;
`ifdef LCD_ARB_LOCK_EN
      lk       <= 1'b0;
`endif
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        IDLE: begin
          gnt <= '0;
`ifdef LCD_ARB_LOCK_EN
          lk  <= 1'b0;
`endif
          if (|req) begin
            ptr <= win;
            cur <= win;
            gnt <= NREQ'(1) << win;
            op  <= wcmd;
            d   <= dat[8*win +: 8];
            if (wcmd > 3'd4) begin
              done <= NREQ'(1) << win;
              err  <= NREQ'(1) << win;
`ifdef LCD_ARB_LOCK_EN
              lk   <= lock[win];
`endif
            end else begin
              state   <= INIT_HI;
              busy    <= 1'b1;
              initlcd <= 1'b1;
            end
          end
        end
        INIT_HI: begin
          initlcd <= 1'b0;
          state   <= INIT_LO;
        end
        INIT_LO: begin
          resetlcd <= op == 3'd0;
          clearlcd <= op == 3'd1;
          homelcd  <= op == 3'd2;
          datalcd  <= op == 3'd3;
          addrlcd  <= op == 3'd4;
          lcddatin <= (op == 3'd3 || op == 3'd4) ? d : 8'h00;
          cnt      <= '0;
          state    <= ISSUE;
        end
        ISSUE: begin
          if (ack || cnt == TO_W'(TIMEOUT - 1)) begin
            resetlcd <= 1'b0;
            clearlcd <= 1'b0;
            homelcd  <= 1'b0;
            datalcd  <= 1'b0;
            addrlcd  <= 1'b0;
            gnt      <= '0;
            done     <= NREQ'(1) << cur;
            err      <= ack ? '0 : NREQ'(1) << cur;
            busy     <= 1'b0;
            state    <= IDLE;
`ifdef LCD_ARB_LOCK_EN
            lk       <= lock[cur];
`endif
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/lcd_cmd_arbiter.md
Name: lcd_cmd_arbiter

Overview:
- Shares the single LCD driver command interface between NREQ independent requesters, e.g. the string writer and a status/debug writer.
- Arbitrates round-robin, one command at a time.
- Wraps each command in the driver's initlcd pulse protocol, holds the command strobe until the matching driver acknowledge, then returns a completion pulse to the requester.
- Sits between LCD content generators and the LCD driver; replaces direct strobe wiring.

Parameters:
- NREQ, 2, number of requesters (legal 2..4).
- TIMEOUT, 65535, max cycles a strobe is held awaiting ack before abort.
- TO_W, 16, timeout counter width (2^TO_W > TIMEOUT).

Ports:
- CCLK  in  1  system clock, all logic on rising edge.
- debpb0_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester command request, level.
- cmd  in  3*NREQ  opcode for requester i in cmd[3i+2:3i]: 0 reset, 1 clear, 2 home, 3 data, 4 addr, 5-7 invalid.
- dat  in  8*NREQ  byte for requester i in dat[8i+7:8i]; used by data/addr.
- gnt  out  NREQ  one-hot, high for the whole command of the granted requester.
- done  out  NREQ  one-cycle completion pulse to requester.
- err  out  NREQ  one-cycle pulse coincident with done on timeout or invalid opcode.
- busy  out  1  high in any state other than IDLE.
- resetlcd, clearlcd, homelcd, datalcd, addrlcd  out  1 each  driver strobes.
- initlcd  out  1  driver init pulse.
- lcddatin  out  8  byte to driver.
- lcdreset, lcdclear, lcdhome, lcddata, lcdaddr  in  1 each  driver acks.

Behaviour:
- Reset (async, debpb0_n=0): all outputs 0; state IDLE; rr pointer = NREQ-1, so requester 0 wins first; counter 0.
- All outputs are registered.
- States: IDLE, INIT_HI, INIT_LO, ISSUE.
- IDLE:
  - If any req, grant the first requester with req=1 searching from (ptr+1) mod NREQ upward with wrap.
  - Latch its cmd/dat, set gnt, set ptr to the winner, go INIT_HI with initlcd=1.
  - Invalid opcode: no INIT/strobe; at the grant edge pulse done+err for that requester, gnt for one cycle only, ptr updated, stay IDLE.
- INIT_HI: next edge initlcd=0, go INIT_LO.
- INIT_LO:
  - Next edge assert the strobe selected by the latched opcode.
  - lcddatin = latched dat for data/addr, 0x00 otherwise.
  - Clear counter, go ISSUE.
- ISSUE:
  - Strobe and lcddatin held.
  - Only the ack matching the opcode is observed; other acks are ignored.
  - On an edge sampling the matching ack=1: strobe=0, gnt=0, done pulse, go IDLE.
  - Else counter++. When counter reaches TIMEOUT: strobe=0, gnt=0, done+err pulse, go IDLE.
- Latency: grant edge k; initlcd high k..k+1; strobe high from edge k+2; with ack already high, done at edge k+3. The next grant can occur at edge k+4.
- Requests:
  - req is level; a requester keeps req high until its done. Deasserting req after grant does not cancel the latched command.
  - cmd/dat changes after grant are ignored until the next grant.
- Simultaneous requests: only one grant per IDLE cycle; losers stay pending.
- lcddatin keeps its last value in IDLE (not cleared).
- Asserting reset in any state drops strobes/initlcd immediately; no done is issued for the aborted command.

Optional Feature:
- Macro LCD_ARB_LOCK_EN.
- When defined:
  - Adds input lock [NREQ].
  - If the granted requester has lock=1 at its done edge, and req=1 in the following IDLE cycle, it is re-granted regardless of ptr.
  - This makes addr+data sequences atomic.
  - The lock is released when lock=0 at any done edge.
- When undefined: port absent; strict round-robin per command.

Test Plan:
- Req0 data 0x41, lcddata rises 3 cycles after datalcd -> initlcd 1 then 0, datalcd held with lcddatin=0x41 for 3 cycles, done[0] single pulse, err=0.
- Req0 and req1 both high from reset with data -> order 0,1,0,1 over 4 commands; gnt never two-hot.
- Req1 clear, lcdclear tied low, TIMEOUT=8 -> clearlcd high exactly 8 cycles then 0; done[1]=err[1]=1 for one cycle; next request serviced normally.
- Req0 opcode 6 -> no strobe, no initlcd, done[0]+err[0] the cycle after request; ptr advances so req1 is granted next.
- Reset asserted mid-ISSUE with addrlcd high -> addrlcd, gnt, busy 0 immediately, without waiting for a clock edge; after release, req0 is granted first.
- LCD_ARB_LOCK_EN: req0 locked addr 0x40 then data 0x55 while req1 pending -> both req0 commands complete before req1's grant.
